// File: rtl/fetch_pkg.sv
// Shared types and sizes for the 4-byte instruction fetch sequencer.
package fetch_pkg;

  localparam int unsigned FETCH_BYTES = 4;
  localparam int unsigned BYTE_W      = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/byte_idx_counter.sv
// 2-bit byte index counter with async clear, sync clear, enable and terminal count.
module byte_idx_counter #(
  parameter logic [1:0] LAST = 2'd3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  output logic [1:0] idx,
  output logic       tc
);

  // Clear wins over enable so a restart never lands on a stale index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= 2'd0;
    end else if (clr) begin
      idx <= 2'd0;
    end else if (en) begin
      idx <= idx + 2'd1;
    end
  end

  assign tc = (idx == LAST);

endmodule

// File: rtl/fetch_byte_sequencer.sv
// Sequences a 4-byte fetch from a byte-wide memory and assembles one instruction word.
// FETCH_BIG_ENDIAN_EN: when defined, byte 0 lands in the MSB lane; default is little-endian.
module fetch_byte_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned N     = 32,
  parameter int unsigned BYTES = FETCH_BYTES
) (
  input  logic                          i_clk,
  input  logic                          i_rst_,
  input  logic                          i_start,
  input  logic [N-1:0]                  i_pc,
  input  logic                          i_abort,
  input  logic                          i_mem_ready,
  input  logic [BYTE_W-1:0]             i_mem_data,
  output logic                          o_mem_rd,
  output logic [N-1:0]                  o_mem_addr,
  output logic [1:0]                    o_byte_idx,
  output logic                          o_busy,
  output logic                          o_valid,
  output logic [FETCH_BYTES*BYTE_W-1:0] o_instr
);

  state_t      state;
  state_t      state_nxt;
  logic [N-1:0] pc_latched;
  logic [1:0]  idx;
  logic [1:0]  lane;
  logic        idx_tc;
  logic        idx_en;
  logic        idx_clr;
  logic        take;

  byte_idx_counter #(
    .LAST (2'(BYTES - 1))
  ) u_idx (
    .clk   (i_clk),
    .rst_n (i_rst_),
    .clr   (idx_clr),
    .en    (idx_en),
    .idx   (idx),
    .tc    (idx_tc)
  );

`ifdef FETCH_BIG_ENDIAN_EN
  assign lane = 2'(BYTES - 1) - idx;
`else
  assign lane = idx;
`endif

  // Next state and counter control; abort outranks a same-cycle ready.
  always_comb begin
    state_nxt = state;
    idx_en    = 1'b0;
    idx_clr   = 1'b0;
    take      = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) begin
          state_nxt = FETCH;
          idx_clr   = 1'b1;
        end
      end
      FETCH: begin
        if (i_abort) begin
          state_nxt = IDLE;
          idx_clr   = 1'b1;
        end else if (i_mem_ready) begin
          take = 1'b1;
          if (idx_tc) begin
            state_nxt = DONE;
          end else begin
            idx_en = 1'b1;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
        idx_clr   = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
        idx_clr   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_) begin
    if (!i_rst_) begin
      state      <= IDLE;
      pc_latched <= '0;
      o_instr    <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && i_start) begin
        pc_latched <= i_pc;
      end
      if (take) begin
        o_instr[BYTE_W*lane +: BYTE_W] <= i_mem_data;
      end
    end
  end

  // Strobes are pure decodes of the state register, so they drop with async reset.
  assign o_mem_rd   = (state == FETCH);
  assign o_busy     = (state != IDLE);
  assign o_valid    = (state == DONE);
  assign o_byte_idx = idx;
  assign o_mem_addr = pc_latched + N'(idx);

endmodule

// File: doc/fetch_byte_sequencer.md
Name: fetch_byte_sequencer

Overview:
- Controller that sequences a 4-byte instruction fetch from a byte-wide memory port, starting at a 32-bit PC.
- Generates byte addresses PC+0..PC+3 and a read strobe, honours a memory-ready handshake (wait states), and assembles the bytes into one 32-bit instruction word.
- Sits between the PC register and the byte memory in the simple processor fetch stage.

Parameters:
- N, 32, PC/address width in bits.
- BYTES, 4, bytes per instruction; fixed at 4, sizes the 2-bit byte index.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_  in  1  reset; asynchronous, active-low.
- i_start  in  1  fetch request; sampled only in IDLE.
- i_pc  in  N  fetch base address; latched when i_start is accepted.
- i_abort  in  1  synchronous abort of an in-progress fetch.
- i_mem_ready  in  1  memory has valid data for the current o_mem_addr this cycle.
- i_mem_data  in  8  byte read data; valid when i_mem_ready=1.
- o_mem_rd  out  1  read strobe; high in FETCH only.
- o_mem_addr  out  N  byte address = pc_latched + byte_idx, modulo 2^N.
- o_byte_idx  out  2  current byte index 0..3.
- o_busy  out  1  high in FETCH and DONE.
- o_valid  out  1  one-cycle pulse: o_instr holds a complete word.
- o_instr  out  32  assembled instruction.

Behaviour:
- Reset (async, i_rst_=0): state=IDLE; pc_latched=0, byte_idx=0, o_instr=0, o_valid=0, o_mem_rd=0, o_busy=0, o_mem_addr=0.
- States: IDLE, FETCH, DONE.
- IDLE: i_start=1 -> latch i_pc, byte_idx=0, go FETCH. i_start=0 -> stay.
- FETCH: o_mem_rd=1; o_mem_addr combinational from registers.
  - i_mem_ready=1 -> write i_mem_data into o_instr[8*idx+7:8*idx].
  - If idx<3, idx++ and stay in FETCH; if idx==3, go DONE.
  - i_mem_ready=0 -> hold idx, address and strobe (wait state, unlimited).
- DONE: o_valid=1 for exactly one cycle, then IDLE and byte_idx=0.
- o_instr: holds its value after DONE until the first byte of the next fetch is written.
- Latency: i_start is sampled at edge E0; with ready held high, bytes are captured at E1..E4 and o_valid is high between E4 and E5. Each wait cycle adds one cycle.
- i_start while busy: ignored, not queued.
- i_abort=1 in FETCH: go IDLE next edge, byte_idx=0, no o_valid; partially written o_instr is undefined-content but stable. i_abort has priority over i_mem_ready in the same cycle.
- i_abort=1 in IDLE or DONE: no effect; o_valid in DONE still pulses.
- Address wrap: pc_latched=0xFFFF_FFFE -> addresses FFFF_FFFE, FFFF_FFFF, 0000_0000, 0000_0001.
- Reset mid-fetch: immediate return to reset values; no o_valid.

Optional Feature:
- Macro FETCH_BIG_ENDIAN_EN.
- Defined: byte idx k goes to o_instr[31-8k:24-8k] (byte 0 is the MSB).
- Undefined (default): little-endian; byte k goes to o_instr[8k+7:8k].
- Addresses and timing are identical in both builds.

Decomposition:
- Shared package fetch_pkg:
  - state enum {IDLE, FETCH, DONE}
  - FETCH_BYTES=4
  - BYTE_W=8
- Sub-module byte_idx_counter: 2-bit up counter with async active-low clear, sync clear, enable, and a terminal-count output (idx==3). It drives o_byte_idx and the FETCH->DONE decision.

Test Plan:
- Reset then i_pc=0x0000_0100, start, ready held 1, data 0x11,0x22,0x33,0x44 -> addresses 0x100..0x103 on consecutive cycles; o_valid high between E4 and E5 with o_instr=0x4433_2211 (0x1122_3344 with FETCH_BIG_ENDIAN_EN).
- Same fetch with i_mem_ready=0 for 2 cycles on byte 1 -> o_mem_addr holds 0x101 for 3 cycles; o_valid delayed by 2 cycles; same o_instr.
- i_pc=0xFFFF_FFFE -> addresses FFFF_FFFE, FFFF_FFFF, 0000_0000, 0000_0001; o_valid pulses normally.
- i_start pulsed again during FETCH -> ignored; exactly one o_valid; the following fetch starts only after IDLE.
- i_abort asserted together with ready on byte 2 -> IDLE next cycle, no o_valid, o_busy=0; a new start at 0x200 fetches 0x200..0x203 correctly.
- i_rst_ driven low asynchronously mid-FETCH (between edges) -> o_mem_rd, o_busy, o_valid, o_byte_idx go 0 immediately; after release, IDLE and o_instr=0.
